// File: rtl/mux_arb.sv
// ---------------------------------------------------------------------------
// mux_arb
//   N-to-1 valid/ready merge with round-robin arbitration and burst locking.
//   While IDLE the grant is chosen combinationally: the first requesting
//   source at or above rr_ptr, wrapping around.  Once a granted beat is
//   either accepted without src_last or left waiting, the grant is frozen in
//   LOCKED until the source's last beat is accepted, after which the pointer
//   moves to the source following the one just served.
//
// Parameters
//   NUM_SRC     number of sources (2..16)
//   DATA_WIDTH  payload width per beat
//   SEL_WIDTH   width of dst_sel / internal indices
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   soft_rst   synchronous clear, same state values as rst
//   src_vld    per-source valid
//   src_rdy    per-source ready (dst_rdy routed to the granted source only)
//   src_data   flattened payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_last   per-source end-of-burst marker
//   dst_vld    merged valid
//   dst_rdy    downstream ready
//   dst_data   payload of the granted source
//   dst_last   src_last of the granted source
//   dst_sel    index of the granted source (rr_ptr when nothing is granted)
// ---------------------------------------------------------------------------
module mux_arb #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          soft_rst,
    input  logic [NUM_SRC-1:0]            src_vld,
    output logic [NUM_SRC-1:0]            src_rdy,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic                          dst_vld,
    input  logic                          dst_rdy,
    output logic [DATA_WIDTH-1:0]         dst_data,
    output logic                          dst_last,
    output logic [SEL_WIDTH-1:0]          dst_sel
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_WIDTH-1:0]   r_lock_idx;
    logic [SEL_WIDTH-1:0]   w_lock_idx_nxt;
    logic [SEL_WIDTH-1:0]   r_rr_ptr;
    logic [SEL_WIDTH-1:0]   w_rr_ptr_nxt;

    // Round-robin search result (meaningful in IDLE only)
    logic                   w_idle_found;
    logic [SEL_WIDTH-1:0]   w_idle_grant;
    int unsigned            w_scan_idx;

    // Effective grant and the muxed view of the granted source
    logic                   w_have_grant;
    logic [SEL_WIDTH-1:0]   w_grant;
    logic                   w_grant_vld;
    logic                   w_grant_last;
    logic [DATA_WIDTH-1:0]  w_grant_data;
    logic                   w_hs;

    // Successor index with explicit wrap so non-power-of-two NUM_SRC never
    // reaches an index >= NUM_SRC.
    function automatic logic [SEL_WIDTH-1:0] f_next_idx(input logic [SEL_WIDTH-1:0] idx);
        if (32'(idx) >= NUM_SRC - 1)
            return '0;
        else
            return idx + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Cyclic priority search starting at rr_ptr.  The inner loop compares
    // against constant indices so every vector select stays in range.
    // -----------------------------------------------------------------------
    always_comb begin
        w_idle_found = 1'b0;
        w_idle_grant = r_rr_ptr;
        w_scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_scan_idx = 32'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_SRC)
                w_scan_idx = w_scan_idx - NUM_SRC;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (!w_idle_found && (w_scan_idx == i) && src_vld[i]) begin
                    w_idle_found = 1'b1;
                    w_idle_grant = SEL_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        w_have_grant = (r_state == LOCKED) || w_idle_found;
        w_grant      = (r_state == LOCKED) ? r_lock_idx : w_idle_grant;
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.  A granted beat in IDLE that is not the last accepted
    // beat (either a non-last handshake or a stalled beat) locks the grant so
    // the downstream sees stable sel/data until the burst completes.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_rr_ptr_nxt   = r_rr_ptr;

        if (soft_rst) begin
            w_state_nxt    = IDLE;
            w_lock_idx_nxt = '0;
            w_rr_ptr_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_found) begin
                        if (w_hs && w_grant_last) begin
                            w_rr_ptr_nxt = f_next_idx(w_idle_grant);
                        end else begin
                            w_state_nxt    = LOCKED;
                            w_lock_idx_nxt = w_idle_grant;
                        end
                    end
                end
                LOCKED: begin
                    if (w_hs && w_grant_last) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = f_next_idx(r_lock_idx);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: zero-latency mux from the granted source.  With no grant
    // (IDLE, nothing requesting) every payload output is zero and dst_sel
    // shows rr_ptr.
    // -----------------------------------------------------------------------
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_last = 1'b0;
        w_grant_data = '0;
        src_rdy      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (w_have_grant && (w_grant == SEL_WIDTH'(i))) begin
                w_grant_vld  = src_vld[i];
                w_grant_last = src_last[i];
                w_grant_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                src_rdy[i]   = dst_rdy;
            end
        end
    end

    assign w_hs     = w_grant_vld & dst_rdy;
    assign dst_vld  = w_grant_vld;
    assign dst_data = w_grant_data;
    assign dst_last = w_grant_last;
    assign dst_sel  = w_grant;

endmodule

// File: tb/tb_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_arb
//   Self-checking bench for mux_arb.  Instance u_a uses defaults (4 sources,
//   32-bit data); instance u_b uses 3 sources to exercise pointer wrap.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.  Accepted beats of u_a are matched against a queue of
//   expected beats filled as stimulus is applied.
// ---------------------------------------------------------------------------
module tb_mux_arb;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         soft_rst;

    // Instance A: 4 x 32
    logic [3:0]   a_src_vld;
    logic [3:0]   a_src_rdy;
    logic [127:0] a_src_data;
    logic [3:0]   a_src_last;
    logic         a_dst_vld;
    logic         a_dst_rdy;
    logic [31:0]  a_dst_data;
    logic         a_dst_last;
    logic [1:0]   a_dst_sel;

    // Instance B: 3 x 8
    logic [2:0]   b_src_vld;
    logic [2:0]   b_src_rdy;
    logic [23:0]  b_src_data;
    logic [2:0]   b_src_last;
    logic         b_dst_vld;
    logic         b_dst_rdy;
    logic [7:0]   b_dst_data;
    logic         b_dst_last;
    logic [1:0]   b_dst_sel;

    exp_t         q_a[$];
    logic [1:0]   q_b[$];
    int           n_total = 0;
    int           n_bad   = 0;

    always #5 clk = ~clk;

    mux_arb u_a (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .src_vld  (a_src_vld),
        .src_rdy  (a_src_rdy),
        .src_data (a_src_data),
        .src_last (a_src_last),
        .dst_vld  (a_dst_vld),
        .dst_rdy  (a_dst_rdy),
        .dst_data (a_dst_data),
        .dst_last (a_dst_last),
        .dst_sel  (a_dst_sel)
    );

    mux_arb #(
        .NUM_SRC    (3),
        .DATA_WIDTH (8)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .src_vld  (b_src_vld),
        .src_rdy  (b_src_rdy),
        .src_data (b_src_data),
        .src_last (b_src_last),
        .dst_vld  (b_dst_vld),
        .dst_rdy  (b_dst_rdy),
        .dst_data (b_dst_data),
        .dst_last (b_dst_last),
        .dst_sel  (b_dst_sel)
    );

    // Scoreboard for instance A: every accepted beat must match the head.
    always @(negedge clk) begin
        if (!rst && a_dst_vld && a_dst_rdy) begin
            n_total++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_beat got sel=%0d data=%h last=%0b required=none",
                         a_dst_sel, a_dst_data, a_dst_last);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if ({a_dst_sel, a_dst_data, a_dst_last} !== {e.sel, e.data, e.last}) begin
                    n_bad++;
                    $display("FAIL a_beat got sel=%0d data=%h last=%0b required sel=%0d data=%h last=%0b",
                             a_dst_sel, a_dst_data, a_dst_last, e.sel, e.data, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a_data(input int unsigned s, input logic [31:0] d);
        a_src_data[s*32 +: 32] = d;
    endtask

    task automatic push_a(input logic [1:0] sel, input logic [31:0] data, input logic last);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        e.last = last;
        q_a.push_back(e);
    endtask

    task automatic check_drained(input string name);
        n_total++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain got pending=%0d required=0", name, q_a.size());
        end
        q_a.delete();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset;
        rst        = 1'b1;
        soft_rst   = 1'b0;
        a_src_vld  = '0;
        a_src_last = '0;
        a_src_data = '0;
        a_dst_rdy  = 1'b1;
        b_src_vld  = '0;
        b_src_last = '0;
        b_src_data = '0;
        b_dst_rdy  = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a_dst_vld, a_dst_data, a_dst_last, a_dst_sel} !== {1'b0, 32'h0, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs got vld=%0b data=%h last=%0b sel=%0d required 0,0,0,0",
                     a_dst_vld, a_dst_data, a_dst_last, a_dst_sel);
        end
        n_total++;
        if (a_src_rdy !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_src_rdy got=%b required=0000", a_src_rdy);
        end
        // Arbitration is live while reset is held: grant comes from rr_ptr=0.
        a_src_vld = 4'b0100;
        #1;
        n_total++;
        if ({a_dst_sel, a_src_rdy} !== {2'd2, 4'b0100}) begin
            n_bad++;
            $display("FAIL reset_comb_grant got sel=%0d rdy=%b required sel=2 rdy=0100",
                     a_dst_sel, a_src_rdy);
        end
        a_src_vld = '0;
        tick();
        rst = 1'b0;
    endtask

    // Four requesters, single-beat bursts: one grant per cycle in order.
    task automatic test_round_robin;
        for (int unsigned i = 0; i < 4; i++)
            set_a_data(i, 32'h1000_0000 | i);
        push_a(2'd0, 32'h1000_0000, 1'b1);
        push_a(2'd1, 32'h1000_0001, 1'b1);
        push_a(2'd2, 32'h1000_0002, 1'b1);
        push_a(2'd3, 32'h1000_0003, 1'b1);
        push_a(2'd0, 32'h1000_0000, 1'b1);
        a_src_vld  = 4'b1111;
        a_src_last = 4'b1111;
        a_dst_rdy  = 1'b1;
        repeat (5) tick();
        a_src_vld = '0;
        @(negedge clk);
        check_drained("round_robin");
        n_total++;
        if ({a_dst_vld, a_dst_sel} !== {1'b0, 2'd1}) begin
            n_bad++;
            $display("FAIL rr_ptr_after_5 got vld=%0b sel=%0d required vld=0 sel=1", a_dst_vld, a_dst_sel);
        end
        tick();
    endtask

    // Source 1 burst of 3 while source 2 keeps requesting (rr_ptr=1).
    task automatic test_burst_lock;
        push_a(2'd1, 32'hB000_0001, 1'b0);
        push_a(2'd1, 32'hB000_0002, 1'b0);
        push_a(2'd1, 32'hB000_0003, 1'b1);
        push_a(2'd2, 32'hC000_0000, 1'b1);
        set_a_data(1, 32'hB000_0001);
        set_a_data(2, 32'hC000_0000);
        a_src_last = 4'b0100;
        a_src_vld  = 4'b0110;
        a_dst_rdy  = 1'b1;
        for (int unsigned beat = 1; beat <= 3; beat++) begin
            @(negedge clk);
            n_total++;
            if ({a_dst_sel, a_src_rdy} !== {2'd1, 4'b0010}) begin
                n_bad++;
                $display("FAIL burst_beat%0d got sel=%0d rdy=%b required sel=1 rdy=0010",
                         beat, a_dst_sel, a_src_rdy);
            end
            tick();
            set_a_data(1, 32'hB000_0000 | (beat + 1));
            if (beat == 2)
                a_src_last = 4'b0110;
        end
        a_src_vld = 4'b0100;
        @(negedge clk);
        n_total++;
        if ({a_dst_sel, a_src_rdy} !== {2'd2, 4'b0100}) begin
            n_bad++;
            $display("FAIL burst_next_grant got sel=%0d rdy=%b required sel=2 rdy=0100",
                     a_dst_sel, a_src_rdy);
        end
        tick();
        a_src_vld = '0;
        @(negedge clk);
        check_drained("burst_lock");
        tick();
    endtask

    // Stall with dst_rdy=0 (rr_ptr=3): grant 0 must hold while 3 requests.
    task automatic test_backpressure;
        push_a(2'd0, 32'hA5A5_A5A5, 1'b1);
        push_a(2'd3, 32'hD3D3_D3D3, 1'b1);
        set_a_data(0, 32'hA5A5_A5A5);
        set_a_data(3, 32'hD3D3_D3D3);
        a_src_last = 4'b1111;
        a_src_vld  = 4'b0001;
        a_dst_rdy  = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if ({a_dst_vld, a_dst_sel, a_dst_data, a_src_rdy} !== {1'b1, 2'd0, 32'hA5A5_A5A5, 4'b0000}) begin
                n_bad++;
                $display("FAIL stall_c%0d got vld=%0b sel=%0d data=%h rdy=%b required 1,0,a5a5a5a5,0000",
                         c, a_dst_vld, a_dst_sel, a_dst_data, a_src_rdy);
            end
            tick();
            if (c == 0)
                a_src_vld = 4'b1001;
        end
        a_dst_rdy = 1'b1;
        @(negedge clk);
        n_total++;
        if (a_src_rdy !== 4'b0001) begin
            n_bad++;
            $display("FAIL stall_release_rdy got=%b required=0001", a_src_rdy);
        end
        tick();
        a_src_vld = 4'b1000;
        tick();
        a_src_vld = '0;
        @(negedge clk);
        check_drained("backpressure");
        tick();
    endtask

    // Async reset while locked on source 2 (rr_ptr=0 before the burst).
    task automatic test_reset_mid_burst;
        push_a(2'd2, 32'hE000_0001, 1'b0);
        set_a_data(2, 32'hE000_0001);
        a_src_last = 4'b0000;
        a_src_vld  = 4'b0100;
        a_dst_rdy  = 1'b1;
        tick();
        a_dst_rdy = 1'b0;
        a_src_vld = 4'b0101;
        set_a_data(0, 32'hF000_0000);
        set_a_data(2, 32'hE000_0002);
        @(negedge clk);
        n_total++;
        if (a_dst_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL lock_before_rst got sel=%0d required=2", a_dst_sel);
        end
        tick();
        rst = 1'b1;
        #1;
        n_total++;
        if ({a_dst_vld, a_dst_sel} !== {1'b1, 2'd0}) begin
            n_bad++;
            $display("FAIL rst_abandons_lock got vld=%0b sel=%0d required vld=1 sel=0", a_dst_vld, a_dst_sel);
        end
        tick();
        rst        = 1'b0;
        a_src_last = 4'b0101;
        push_a(2'd0, 32'hF000_0000, 1'b1);
        push_a(2'd2, 32'hE000_0002, 1'b1);
        a_dst_rdy  = 1'b1;
        tick();
        tick();
        a_src_vld = '0;
        @(negedge clk);
        check_drained("reset_mid_burst");
        tick();
    endtask

    // soft_rst on the last-beat handshake of source 1 (rr_ptr=3 beforehand).
    task automatic test_soft_rst;
        push_a(2'd1, 32'h1111_1111, 1'b1);
        set_a_data(1, 32'h1111_1111);
        a_src_last = 4'b1111;
        a_src_vld  = 4'b0010;
        a_dst_rdy  = 1'b1;
        soft_rst   = 1'b1;
        tick();
        soft_rst = 1'b0;
        set_a_data(0, 32'h0000_0A0A);
        set_a_data(2, 32'h2222_2222);
        push_a(2'd0, 32'h0000_0A0A, 1'b1);
        push_a(2'd2, 32'h2222_2222, 1'b1);
        a_src_vld = 4'b0101;
        @(negedge clk);
        n_total++;
        if (a_dst_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL soft_rst_priority got sel=%0d required=0", a_dst_sel);
        end
        tick();
        tick();
        a_src_vld = '0;
        @(negedge clk);
        check_drained("soft_rst");
        tick();
    endtask

    // Nothing requesting: outputs idle, dst_sel shows rr_ptr (3 here).
    task automatic test_idle_outputs;
        a_src_vld  = '0;
        a_src_last = 4'b1111;
        a_dst_rdy  = 1'b1;
        @(negedge clk);
        n_total++;
        if ({a_dst_vld, a_dst_data, a_dst_last, a_dst_sel, a_src_rdy} !==
            {1'b0, 32'h0, 1'b0, 2'd3, 4'b0000}) begin
            n_bad++;
            $display("FAIL idle_outputs got vld=%0b data=%h last=%0b sel=%0d rdy=%b required 0,0,0,3,0000",
                     a_dst_vld, a_dst_data, a_dst_last, a_dst_sel, a_src_rdy);
        end
        tick();
    endtask

    // NUM_SRC=3: pointer must wrap 2 -> 0 and never show 3.
    task automatic test_wrap_mod3;
        logic [1:0] e;
        for (int unsigned i = 0; i < 3; i++)
            b_src_data[i*8 +: 8] = 8'h30 + 8'(i);
        for (int unsigned k = 0; k < 8; k++)
            q_b.push_back(2'(k % 3));
        b_src_vld  = 3'b111;
        b_src_last = 3'b111;
        b_dst_rdy  = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            e = q_b.pop_front();
            n_total++;
            if ({b_dst_vld, b_dst_sel, b_dst_data} !== {1'b1, e, 8'h30 + {6'd0, e}}) begin
                n_bad++;
                $display("FAIL mod3_grant%0d got vld=%0b sel=%0d data=%h required vld=1 sel=%0d data=%h",
                         k, b_dst_vld, b_dst_sel, b_dst_data, e, 8'h30 + {6'd0, e});
            end
            tick();
        end
        b_src_vld = '0;
        @(negedge clk);
        n_total++;
        if (b_dst_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL mod3_ptr_after got sel=%0d required=2", b_dst_sel);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_reset_mid_burst();
        test_soft_rst();
        test_idle_outputs();
        test_wrap_mod3();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
